// File: rtl/bldc_commutation_controller_pkg.sv
// Shared types and step table for the six-step BLDC commutation controller.
package bldc_commutation_controller_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } rotation_direction_t;

    typedef enum logic [1:0] {
        CS_IDLE     = 2'd0,
        CS_DEADTIME = 2'd1,
        CS_DRIVE    = 2'd2,
        CS_FAULT    = 2'd3
    } commutation_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE         = 2'd0,
        FAULT_INVALID_HALL = 2'd1,
        FAULT_STALL        = 2'd2
    } fault_code_t;

    localparam logic [2:0] SECTOR_INVALID = 3'b111;

    // Returns {hi[2:0], lo[2:0]} with bit order {C,B,A}.
    function automatic logic [5:0] step_pattern(input logic [2:0] step);
        logic [5:0] pat;
        pat = 6'b000_000;
        unique case (step)
            3'd0: pat = 6'b001_010;
            3'd1: pat = 6'b001_100;
            3'd2: pat = 6'b010_100;
            3'd3: pat = 6'b010_001;
            3'd4: pat = 6'b100_001;
            3'd5: pat = 6'b100_010;
            default: pat = 6'b000_000;
        endcase
        return pat;
    endfunction

    function automatic logic [2:0] target_step(
        input logic [2:0]          sec,
        input rotation_direction_t dir
    );
        logic [2:0] step;
        step = 3'd0;
        if (dir == DIR_CCW)
            step = (sec >= 3'd2) ? sec - 3'd2 : sec + 3'd4;
        else
            step = (sec == 3'd5) ? 3'd0 : sec + 3'd1;
        return step;
    endfunction

endpackage

// File: rtl/bldc_commutation_controller.sv
// Six-step commutation sequencer with dead-time insertion,
// stall / invalid-hall fault detection and a commutation counter.
module bldc_commutation_controller
    import bldc_commutation_controller_pkg::*;
#(
    parameter int clk_freq_hz     = 27_000_000,
    parameter int dead_time_ticks = 27,
    parameter int stall_ticks     = clk_freq_hz / 2,
    parameter int counter_width   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  rotation_direction_t      dir_cmd,
    input  logic [2:0]               sector,
    input  logic                     pwm_in,
    output logic [2:0]               phase_hi,
    output logic [2:0]               phase_lo,
    output commutation_state_t       state,
    output fault_code_t              fault_code,
    output logic [counter_width-1:0] commutation_count
);

    localparam int W = counter_width;

    logic [W-1:0] dead_cnt;
    logic [W-1:0] stall_cnt;
    logic [2:0]   active_step;
    logic [2:0]   sector_q;

    logic       sector_ok;
    logic       sector_moved;
    logic       running;
    logic       run_req;
    logic       stall_hit;
    logic       dead_done;
    logic [2:0] target;
    logic [5:0] next_pat;
    logic [5:0] cur_pat;

    always_comb begin
        sector_ok    = (sector <= 3'd5);
        sector_moved = (sector != sector_q);
        running      = (state == CS_DEADTIME) || (state == CS_DRIVE);
        run_req      = enable && (dir_cmd != DIR_NONE);
        target       = target_step(sector, dir_cmd);
        next_pat     = step_pattern(target);
        cur_pat      = step_pattern(active_step);
        stall_hit    = running && !sector_moved &&
                       (stall_cnt == W'(stall_ticks - 1));
        dead_done    = (dead_cnt == W'(dead_time_ticks - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= CS_IDLE;
            fault_code        <= FAULT_NONE;
            phase_hi          <= 3'b000;
            phase_lo          <= 3'b000;
            commutation_count <= '0;
            active_step       <= 3'd0;
            dead_cnt          <= '0;
            stall_cnt         <= '0;
            sector_q          <= SECTOR_INVALID;
        end else begin
            sector_q  <= sector;
            stall_cnt <= (running && !sector_moved) ? stall_cnt + 1'b1 : '0;
            phase_hi  <= 3'b000;
            phase_lo  <= 3'b000;

            case (state)
                CS_IDLE: begin
                    if (enable && !sector_ok) begin
                        state      <= CS_FAULT;
                        fault_code <= FAULT_INVALID_HALL;
                    end else if (run_req && sector_ok) begin
                        state    <= CS_DEADTIME;
                        dead_cnt <= '0;
                    end
                end

                CS_DEADTIME, CS_DRIVE: begin
                    if (!sector_ok) begin
                        state      <= CS_FAULT;
                        fault_code <= FAULT_INVALID_HALL;
                    end else if (stall_hit) begin
                        state      <= CS_FAULT;
                        fault_code <= FAULT_STALL;
                    end else if (!run_req) begin
                        state <= CS_IDLE;
                    end else if (state == CS_DEADTIME) begin
                        // Target is re-evaluated only at expiry.
                        if (dead_done) begin
                            state             <= CS_DRIVE;
                            active_step       <= target;
                            commutation_count <= commutation_count + 1'b1;
                            phase_hi          <= next_pat[5:3] & {3{pwm_in}};
                            phase_lo          <= next_pat[2:0];
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end else if (target != active_step) begin
                        state    <= CS_DEADTIME;
                        dead_cnt <= '0;
                    end else begin
                        phase_hi <= cur_pat[5:3] & {3{pwm_in}};
                        phase_lo <= cur_pat[2:0];
                    end
                end

                CS_FAULT: begin
                    if (!enable) begin
                        state      <= CS_IDLE;
                        fault_code <= FAULT_NONE;
                    end
                end

                default: state <= CS_IDLE;
            endcase
        end
    end

    no_shoot_through: assert property (
        @(posedge clk) disable iff (reset) (phase_hi & phase_lo) == 3'b000
    );

endmodule

// File: tb/tb_bldc_commutation_controller.sv
// Randomized scoreboard bench for bldc_commutation_controller.
module tb_bldc_commutation_controller;
    import bldc_commutation_controller_pkg::*;

    localparam int DT  = 4;
    localparam int STL = 100;
    localparam int CW  = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    rotation_direction_t dir_cmd = DIR_NONE;
    logic [2:0]          sector = 3'd0;
    logic                pwm_in = 1'b1;
    logic [2:0]          phase_hi;
    logic [2:0]          phase_lo;
    commutation_state_t  state;
    fault_code_t         fault_code;
    logic [CW-1:0]       commutation_count;

    bldc_commutation_controller #(
        .clk_freq_hz    (1000),
        .dead_time_ticks(DT),
        .stall_ticks    (STL),
        .counter_width  (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .dir_cmd          (dir_cmd),
        .sector           (sector),
        .pwm_in           (pwm_in),
        .phase_hi         (phase_hi),
        .phase_lo         (phase_lo),
        .state            (state),
        .fault_code       (fault_code),
        .commutation_count(commutation_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]         hi;
        logic [2:0]         lo;
        commutation_state_t st;
        fault_code_t        fc;
        logic [CW-1:0]      cnt;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   rnd_pwm = 1'b0;

    // Phase index (A=0,B=1,C=2) driven high / low in each step.
    int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
    int lo_ph[6] = '{1, 2, 2, 0, 0, 1};

    commutation_state_t m_st;
    fault_code_t        m_fc;
    int                 m_step;
    int                 m_cnt;
    int                 m_dead_left;
    int                 m_still;
    int                 m_prev;

    function automatic int tgt(int s, rotation_direction_t d);
        return (d == DIR_CCW) ? (s + 4) % 6 : (s + 1) % 6;
    endfunction

    task automatic model_reset();
        m_st = CS_IDLE;
        m_fc = FAULT_NONE;
        m_step = 0;
        m_cnt = 0;
        m_dead_left = 0;
        m_still = 0;
        m_prev = 7;
    endtask

    task automatic push_now(bit drive, bit pwm);
        exp_t e;
        e.hi = 3'b000;
        e.lo = 3'b000;
        if (drive) begin
            e.lo = 3'(1 << lo_ph[m_step]);
            if (pwm)
                e.hi = 3'(1 << hi_ph[m_step]);
        end
        e.st = m_st;
        e.fc = m_fc;
        e.cnt = CW'(m_cnt);
        sb.push_back(e);
    endtask

    // Advances the model by one clock edge using the current inputs.
    task automatic model_step();
        int  s;
        bit  valid;
        bit  moved;
        bit  run;
        bit  drive;
        s = int'(sector);
        valid = (s < 6);
        moved = (s != m_prev);
        m_prev = s;
        run = (m_st == CS_DEADTIME) || (m_st == CS_DRIVE);
        m_still = (!run || moved) ? 0 : m_still + 1;
        drive = 1'b0;
        if (m_st == CS_IDLE) begin
            if (enable && !valid) begin
                m_st = CS_FAULT;
                m_fc = FAULT_INVALID_HALL;
            end else if (enable && dir_cmd != DIR_NONE) begin
                m_st = CS_DEADTIME;
                m_dead_left = DT;
            end
        end else if (run) begin
            if (!valid) begin
                m_st = CS_FAULT;
                m_fc = FAULT_INVALID_HALL;
            end else if (m_still == STL) begin
                m_st = CS_FAULT;
                m_fc = FAULT_STALL;
            end else if (!enable || dir_cmd == DIR_NONE) begin
                m_st = CS_IDLE;
            end else if (m_st == CS_DEADTIME) begin
                m_dead_left--;
                if (m_dead_left == 0) begin
                    m_st = CS_DRIVE;
                    m_step = tgt(s, dir_cmd);
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    drive = 1'b1;
                end
            end else if (tgt(s, dir_cmd) != m_step) begin
                m_st = CS_DEADTIME;
                m_dead_left = DT;
            end else begin
                drive = 1'b1;
            end
        end else begin
            if (!enable) begin
                m_st = CS_IDLE;
                m_fc = FAULT_NONE;
            end
        end
        push_now(drive, pwm_in);
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = rnd_pwm ? 1'($urandom % 2) : 1'b1;
            model_step();
            @(negedge clk);
        end
    endtask

    // Asynchronous reset pulse launched between edges.
    task automatic reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        push_now(1'b0, 1'b0);
        push_now(1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared++;
                if (phase_hi !== e.hi || phase_lo !== e.lo ||
                    state !== e.st || fault_code !== e.fc ||
                    commutation_count !== e.cnt) begin
                    mismatched++;
                    $display("FAIL outputs t=%0t got hi=%b lo=%b st=%s fc=%s cnt=%0d want hi=%b lo=%b st=%s fc=%s cnt=%0d",
                             $time, phase_hi, phase_lo, state.name(),
                             fault_code.name(), commutation_count, e.hi,
                             e.lo, e.st.name(), e.fc.name(), e.cnt);
                end
                compared++;
                if ((phase_hi & phase_lo) !== 3'b000) begin
                    mismatched++;
                    $display("FAIL overlap t=%0t got hi=%b lo=%b want disjoint",
                             $time, phase_hi, phase_lo);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int r;
        int len;
        @(negedge clk);
        reset_pulse();

        enable = 1'b1;
        sector = 3'd0;
        dir_cmd = DIR_CW;
        run_cycles(10);

        for (int i = 1; i <= 6; i++) begin
            sector = 3'(i % 6);
            run_cycles(20);
        end

        sector = 3'd1;
        run_cycles(20);
        sector = 3'd2;
        run_cycles(20);
        dir_cmd = DIR_CCW;
        run_cycles(20);

        run_cycles(110);
        enable = 1'b0;
        run_cycles(3);
        enable = 1'b1;
        run_cycles(12);

        sector = SECTOR_INVALID;
        run_cycles(4);
        sector = 3'd3;
        run_cycles(6);
        enable = 1'b0;
        run_cycles(2);
        enable = 1'b1;
        run_cycles(12);

        rnd_pwm = 1'b1;
        run_cycles(20);

        for (int k = 0; k < 250; k++) begin
            r = int'($urandom % 100);
            if (r < 5)
                sector = SECTOR_INVALID;
            else if (r < 80)
                sector = 3'($urandom % 6);
            if ($urandom % 100 < 10)
                dir_cmd = rotation_direction_t'($urandom % 3);
            enable = ($urandom % 100) >= 6;
            len = ($urandom % 100 < 3) ? 110 : int'($urandom_range(1, 25));
            run_cycles(len);
        end

        enable = 1'b1;
        dir_cmd = DIR_CW;
        sector = 3'd4;
        run_cycles(15);
        reset_pulse();
        run_cycles(10);

        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected outputs never observed, want 0",
                     sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
